// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one synchronous RAM between fetch and data ports
//
// Purpose: lets the cpu instruction-fetch port (i_*) and data port (d_*) share a
// single-port synchronous memory (m_*). Requests are accepted with a combinational
// req/ready handshake. Only one read may be in flight, and read data returns through
// the owner's rdata register with a one-cycle rvalid pulse.
//
// Ports:
//   clk, n_reset                        clock (rising edge), async active-low reset
//   i_req, i_addr -> i_ready            fetch request / accept (always a read)
//   i_rvalid, i_rdata                   fetch data pulse / held fetch data
//   d_req, d_we, d_addr, d_wdata        data request (read or write)
//   d_ready                             data request accepted
//   d_rvalid, d_rdata                   data read pulse / held read data
//   m_en, m_we, m_addr, m_wdata         memory access, driven in the accept cycle
//   m_rdata                             memory read data, LATENCY cycles after m_en
//   busy                                a read is in flight
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;    // last grant: 0 = fetch port, 1 = data port
  logic              owner_q, owner_d;  // owner of the in-flight read, same encoding
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic accept_ok;
  logic grant_data;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready   = 1'b0;
    d_ready   = 1'b0;

    // Readies are combinational from req, so they are gated by reset to keep
    // every output low while n_reset is held.
    accept_ok  = n_reset && (state_q != S_WAIT);
    // Data wins when alone, or when both request and fetch was granted last.
    grant_data = d_req && !(i_req && last_q);

    if (accept_ok && (i_req || d_req)) begin
      d_ready = grant_data;
      i_ready = !grant_data;
    end

    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) d_rdata_d = m_rdata;
          else         i_rdata_d = m_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A read accept overrides the IDLE default; writes finish in the accept cycle.
    if (i_ready || d_ready) begin
      last_d = d_ready;
      if (i_ready || !d_we) begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(LATENCY - 1);
        owner_d = d_ready;
      end
    end
  end

  assign m_en     = i_ready || d_ready;
  assign m_we     = d_ready && d_we;
  assign m_addr   = d_ready ? d_addr : (i_ready ? i_addr : '0);
  assign m_wdata  = (d_ready && d_we) ? d_wdata : '0;
  assign i_rvalid = (state_q == S_RESP) && !owner_q;
  assign d_rvalid = (state_q == S_RESP) && owner_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        i_req, i_ready, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_en, m_we, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment RAM driven by the DUT's memory port, read data delayed L cycles.
  logic [31:0] ram [16];
  logic [31:0] pipe [L];
  assign m_rdata = pipe[L-1];

  always @(posedge clk) begin
    if (m_en && m_we) ram[m_addr[5:2]] <= m_wdata;
    for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= (m_en && !m_we) ? ram[m_addr[5:2]] : $urandom;
  end

  // Reference model: expectations derived from request timestamps.
  logic [31:0] shadow [16];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, t_acc = 0;
  bit          pend = 0, own = 0, last = 0;
  logic [31:0] pend_data, e_ird = 0, e_drd = 0;
  bit          g_i, g_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic cycle();
    bit resp, waitst, gd, acc_i, acc_d, e_we;
    logic [31:0] e_ma, e_mw, ra;
    @(negedge clk);
    acc_i = 0; acc_d = 0;
    if (!n_reset) begin
      chk("rst_i_ready", i_ready, 0);  chk("rst_d_ready", d_ready, 0);
      chk("rst_m_en", m_en, 0);        chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);    chk("rst_m_wdata", m_wdata, 0);
      chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_i_rdata", i_rdata, 0);  chk("rst_d_rdata", d_rdata, 0);
      chk("rst_busy", busy, 0);
      pend = 0; last = 0; e_ird = 0; e_drd = 0;
    end else begin
      resp   = pend && (cyc == t_acc + L + 1);
      waitst = pend && (cyc > t_acc) && (cyc <= t_acc + L);
      if (resp) begin
        if (own) e_drd = pend_data;
        else     e_ird = pend_data;
      end
      if (!waitst && (i_req || d_req)) begin
        gd = d_req && !(i_req && last);
        acc_d = gd; acc_i = !gd;
      end
      e_we = acc_d && d_we;
      e_ma = acc_d ? d_addr : (acc_i ? i_addr : 32'h0);
      e_mw = e_we ? d_wdata : 32'h0;
      chk("i_ready", i_ready, acc_i);   chk("d_ready", d_ready, acc_d);
      chk("m_en", m_en, acc_i | acc_d); chk("m_we", m_we, e_we);
      chk("m_addr", m_addr, e_ma);      chk("m_wdata", m_wdata, e_mw);
      chk("i_rvalid", i_rvalid, resp && !own);
      chk("d_rvalid", d_rvalid, resp && own);
      chk("i_rdata", i_rdata, e_ird);   chk("d_rdata", d_rdata, e_drd);
      chk("busy", busy, waitst);
      if (resp) pend = 0;
      if (acc_i || acc_d) begin
        last = acc_d;
        ra = acc_d ? d_addr : i_addr;
        if (e_we) shadow[ra[5:2]] = d_wdata;
        else begin
          pend = 1; t_acc = cyc; own = acc_d; pend_data = shadow[ra[5:2]];
        end
      end
    end
    g_i = acc_i; g_d = acc_d;
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    bit i_act, d_act;
    for (int k = 0; k < 16; k++) begin
      ram[k] = $urandom; shadow[k] = ram[k];
    end
    ram[1] = 32'hDEADBEEF; shadow[1] = 32'hDEADBEEF;
    for (int k = 0; k < L; k++) pipe[k] = 0;
    n_reset = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    cycle(); cycle();
    n_reset = 1;
    cycle();

    // Single fetch at 0x4 with 0xDEADBEEF in memory.
    i_req = 1; i_addr = 32'h4; #1;
    chk("t2_i_ready", i_ready, 1); chk("t2_m_en", m_en, 1);
    chk("t2_m_addr", m_addr, 32'h4); chk("t2_m_we", m_we, 0);
    cycle(); i_req = 0;
    cycle(); cycle();
    #1 chk("t2_i_rvalid", i_rvalid, 1); chk("t2_i_rdata", i_rdata, 32'hDEADBEEF);
    cycle();
    #1 chk("t2_i_rvalid_off", i_rvalid, 0); chk("t2_i_rdata_hold", i_rdata, 32'hDEADBEEF);
    cycle();

    // Both read continuously after reset: data first, then strict alternation.
    n_reset = 0; cycle(); n_reset = 1;
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h10;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k % 3 == 0) chk("t3_grant", {i_ready, d_ready}, (k % 6 == 0) ? 2'b01 : 2'b10);
      cycle();
    end
    i_req = 0; d_req = 0;
    repeat (4) cycle();

    // Back-to-back writes.
    d_req = 1; d_we = 1; d_addr = 32'h0; d_wdata = 32'h01FE; #1;
    chk("t4_d_ready0", d_ready, 1); chk("t4_m_we0", m_we, 1);
    chk("t4_m_addr0", m_addr, 32'h0); chk("t4_m_wdata0", m_wdata, 32'h01FE);
    cycle();
    d_addr = 32'h4; d_wdata = 32'h00FF; #1;
    chk("t4_d_ready1", d_ready, 1); chk("t4_m_we1", m_we, 1);
    chk("t4_m_addr1", m_addr, 32'h4); chk("t4_m_wdata1", m_wdata, 32'h00FF);
    cycle();
    d_req = 0; d_we = 0;
    repeat (2) cycle();

    // Write raised during a fetch WAIT is held off until the fetch RESP cycle.
    i_req = 1; i_addr = 32'h8;
    cycle(); i_req = 0;
    d_req = 1; d_we = 1; d_addr = 32'hC; d_wdata = 32'h1234_5678; #1;
    chk("t5_d_ready_w1", d_ready, 0);
    cycle(); #1 chk("t5_d_ready_w2", d_ready, 0);
    cycle(); #1 chk("t5_i_rvalid", i_rvalid, 1); chk("t5_d_ready", d_ready, 1);
    cycle(); d_req = 0; d_we = 0;
    repeat (2) cycle();

    // Reset pulsed during WAIT discards the read.
    i_req = 1; i_addr = 32'h10;
    cycle(); i_req = 0;
    #1 chk("t6_busy_before", busy, 1);
    d_req = 1; n_reset = 0; #1;
    chk("t6_busy_async", busy, 0); chk("t6_m_en_async", m_en, 0); chk("t6_d_ready_async", d_ready, 0);
    cycle(); n_reset = 1; d_req = 0; #1;
    chk("t6_busy_after", busy, 0);
    repeat (3) cycle();
    i_req = 1; #1 chk("t6_i_ready_next", i_ready, 1);
    cycle(); i_req = 0;
    repeat (4) cycle();

    // Randomised traffic with held requests and occasional reset pulses.
    i_act = 0; d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_act && ($urandom % 3 == 0)) begin
        i_act = 1; i_req = 1; i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_act && ($urandom % 3 == 0)) begin
        d_act = 1; d_req = 1; d_we = $urandom % 2;
        d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom;
      end
      n_reset = ($urandom % 250 != 0);
      cycle();
      if (g_i) begin i_act = 0; i_req = 0; end
      if (g_d) begin d_act = 0; d_req = 0; end
    end
    n_reset = 1; i_req = 0; d_req = 0;
    repeat (5) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
